// File: rtl/frame_link.sv
// Byte-serial framing link: assembles NBYTES received bytes into one wide frame
// and serialises a latched wide frame back out byte by byte. The two paths are independent.
module frame_link #(
  parameter int BYTE_W    = 8,
  parameter int NBYTES    = 10,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        rx_byte,
  input  logic                     rx_valid,
  output logic [NBYTES*BYTE_W-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     rx_overrun,
  output logic                     timeout_err,
  input  logic [NBYTES*BYTE_W-1:0] tx_frame,
  input  logic                     tx_start,
  output logic                     tx_busy,
  output logic [BYTE_W-1:0]        tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int CW = $clog2(NBYTES);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NBYTES - 1);
  localparam logic [TW-1:0] IDLE_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  // Element k of a frame occupies bits [k*BYTE_W +: BYTE_W].
  typedef logic [NBYTES-1:0][BYTE_W-1:0] frame_t;

  typedef enum logic [1:0] {R_IDLE, R_FILL, R_HOLD} rx_state_e;
  typedef enum logic       {T_IDLE, T_SEND}         tx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_slot_q, rx_slot_d;
  logic [TW-1:0]   rx_idle_q, rx_idle_d;
  frame_t          rx_frame_q, rx_frame_d;
  logic            rx_overrun_q, rx_overrun_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CW-1:0]   rx_elem;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_idx_q, tx_idx_d;
  frame_t          tx_frame_q, tx_frame_d;
  logic [CW-1:0]   tx_elem;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q    <= R_IDLE;
      rx_slot_q     <= '0;
      rx_idle_q     <= '0;
      rx_frame_q    <= '0;
      rx_overrun_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_state_q    <= T_IDLE;
      tx_idx_q      <= '0;
      tx_frame_q    <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_slot_q     <= rx_slot_d;
      rx_idle_q     <= rx_idle_d;
      rx_frame_q    <= rx_frame_d;
      rx_overrun_q  <= rx_overrun_d;
      timeout_err_q <= timeout_err_d;
      tx_state_q    <= tx_state_d;
      tx_idx_q      <= tx_idx_d;
      tx_frame_q    <= tx_frame_d;
    end
  end

  // Receive path; an arriving byte always wins over a timeout firing in the same cycle.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_slot_d     = rx_slot_q;
    rx_idle_d     = rx_idle_q;
    rx_frame_d    = rx_frame_q;
    rx_overrun_d  = 1'b0;
    timeout_err_d = 1'b0;
    rx_elem       = (MSB_FIRST != 0) ? (LAST_SLOT - rx_slot_q) : rx_slot_q;
    case (rx_state_q)
      R_IDLE, R_FILL: begin
        if (rx_valid) begin
          rx_frame_d[rx_elem] = rx_byte;
          rx_idle_d           = '0;
          if (rx_slot_q == LAST_SLOT) begin
            rx_state_d = R_HOLD;
            rx_slot_d  = '0;
          end else begin
            rx_state_d = R_FILL;
            rx_slot_d  = rx_slot_q + 1'b1;
          end
        end else if ((rx_state_q == R_FILL) && (TIMEOUT != 0)) begin
          if (rx_idle_q == IDLE_LAST) begin
            rx_state_d    = R_IDLE;
            rx_slot_d     = '0;
            rx_idle_d     = '0;
            rx_frame_d    = '0;
            timeout_err_d = 1'b1;
          end else begin
            rx_idle_d = rx_idle_q + 1'b1;
          end
        end
      end
      R_HOLD: begin
        rx_overrun_d = rx_valid;
        if (frame_ready) begin
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_frame_d = tx_frame_q;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_start) begin
          tx_frame_d = tx_frame;
          tx_idx_d   = '0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_ready) begin
          if (tx_idx_q == LAST_SLOT) begin
            tx_state_d = T_IDLE;
            tx_idx_d   = '0;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign tx_elem     = (MSB_FIRST != 0) ? (LAST_SLOT - tx_idx_q) : tx_idx_q;
  assign tx_valid    = (tx_state_q == T_SEND);
  assign tx_busy     = (tx_state_q == T_SEND);
  assign tx_byte     = tx_valid ? tx_frame_q[tx_elem] : '0;

  assign frame_data  = rx_frame_q;
  assign frame_valid = (rx_state_q == R_HOLD);
  assign rx_overrun  = rx_overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_link.sv
// Bench for frame_link: two instances (MSB-first and LSB-first, 16-cycle timeout) driven
// with identical directed and random stimulus, checked against a queue-based frame model.
module tb_frame_link;

  localparam int NB  = 10;
  localparam int FW  = 80;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          frame_ready;
  logic [FW-1:0] tx_frame;
  logic          tx_start;
  logic          tx_ready;

  logic [FW-1:0] frame_data_m, frame_data_l;
  logic          frame_valid_m, frame_valid_l;
  logic          rx_overrun_m, rx_overrun_l;
  logic          timeout_err_m, timeout_err_l;
  logic          tx_busy_m, tx_busy_l;
  logic [7:0]    tx_byte_m, tx_byte_l;
  logic          tx_valid_m, tx_valid_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]    rxq[$];
  bit            exp_hold;
  int            exp_idle;
  logic [FW-1:0] exp_frame_m, exp_frame_l;
  bit            exp_ovr, exp_tmo;
  logic [7:0]    txq_m[$], txq_l[$];
  logic [7:0]    sent_m[$], sent_l[$];

  always #5 clk = ~clk;

  frame_link #(.BYTE_W(8), .NBYTES(NB), .MSB_FIRST(1), .TIMEOUT(TMO)) dut_m (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_data(frame_data_m), .frame_valid(frame_valid_m), .frame_ready(frame_ready),
    .rx_overrun(rx_overrun_m), .timeout_err(timeout_err_m),
    .tx_frame(tx_frame), .tx_start(tx_start), .tx_busy(tx_busy_m),
    .tx_byte(tx_byte_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready)
  );

  frame_link #(.BYTE_W(8), .NBYTES(NB), .MSB_FIRST(0), .TIMEOUT(TMO)) dut_l (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_data(frame_data_l), .frame_valid(frame_valid_l), .frame_ready(frame_ready),
    .rx_overrun(rx_overrun_l), .timeout_err(timeout_err_l),
    .tx_frame(tx_frame), .tx_start(tx_start), .tx_busy(tx_busy_l),
    .tx_byte(tx_byte_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready)
  );

  // Advances the model by one clock using the inputs currently applied.
  function automatic void modelStep();
    exp_ovr = 1'b0;
    exp_tmo = 1'b0;
    if (rst) begin
      rxq.delete();
      exp_hold = 1'b0;
      exp_idle = 0;
      txq_m.delete();
      txq_l.delete();
      return;
    end
    if (exp_hold) begin
      exp_ovr = rx_valid;
      if (frame_ready) exp_hold = 1'b0;
    end else if (rx_valid) begin
      rxq.push_back(rx_byte);
      exp_idle = 0;
      if (rxq.size() == NB) begin
        exp_frame_m = '0;
        exp_frame_l = '0;
        for (int i = 0; i < NB; i++) begin
          exp_frame_m = {exp_frame_m[FW-9:0], rxq[i]};
          exp_frame_l = exp_frame_l | ({72'h0, rxq[i]} << (8 * i));
        end
        exp_hold = 1'b1;
        rxq.delete();
      end
    end else if (rxq.size() != 0) begin
      exp_idle++;
      if (exp_idle == TMO) begin
        rxq.delete();
        exp_idle = 0;
        exp_tmo  = 1'b1;
      end
    end
    if (txq_m.size() != 0) begin
      if (tx_ready) begin
        void'(txq_m.pop_front());
        void'(txq_l.pop_front());
      end
    end else if (tx_start) begin
      for (int i = 0; i < NB; i++) begin
        txq_m.push_back(8'(tx_frame >> (8 * (NB - 1 - i))));
        txq_l.push_back(8'(tx_frame >> (8 * i)));
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic checkDut(input string nm, input logic fv, input logic [FW-1:0] fd,
                          input logic ovr, input logic tmo, input logic tv, input logic tbusy,
                          input logic [7:0] tbyte, input logic [FW-1:0] efr,
                          input bit ebusy, input logic [7:0] efront);
    checkOutput({nm, ".frame_valid"}, FW'(fv), FW'(exp_hold));
    if (exp_hold) checkOutput({nm, ".frame_data"}, fd, efr);
    checkOutput({nm, ".rx_overrun"}, FW'(ovr), FW'(exp_ovr));
    checkOutput({nm, ".timeout_err"}, FW'(tmo), FW'(exp_tmo));
    checkOutput({nm, ".tx_valid"}, FW'(tv), FW'(ebusy));
    checkOutput({nm, ".tx_busy"}, FW'(tbusy), FW'(ebusy));
    if (ebusy) checkOutput({nm, ".tx_byte"}, FW'(tbyte), FW'(efront));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".m.frame_data"}, frame_data_m, '0);
    checkOutput({tag, ".l.frame_data"}, frame_data_l, '0);
    checkOutput({tag, ".m.ctrl"}, FW'({frame_valid_m, rx_overrun_m, timeout_err_m, tx_busy_m, tx_valid_m}), '0);
    checkOutput({tag, ".l.ctrl"}, FW'({frame_valid_l, rx_overrun_l, timeout_err_l, tx_busy_l, tx_valid_l}), '0);
    checkOutput({tag, ".m.tx_byte"}, FW'(tx_byte_m), '0);
    checkOutput({tag, ".l.tx_byte"}, FW'(tx_byte_l), '0);
  endtask

  // One clock cycle with the current inputs, then compare both instances to the model.
  task automatic applyStimulus();
    if (tx_valid_m && tx_ready) sent_m.push_back(tx_byte_m);
    if (tx_valid_l && tx_ready) sent_l.push_back(tx_byte_l);
    modelStep();
    @(posedge clk);
    #1;
    checkDut("m", frame_valid_m, frame_data_m, rx_overrun_m, timeout_err_m, tx_valid_m, tx_busy_m,
             tx_byte_m, exp_frame_m, txq_m.size() != 0, (txq_m.size() != 0) ? txq_m[0] : 8'h00);
    checkDut("l", frame_valid_l, frame_data_l, rx_overrun_l, timeout_err_l, tx_valid_l, tx_busy_l,
             tx_byte_l, exp_frame_l, txq_l.size() != 0, (txq_l.size() != 0) ? txq_l[0] : 8'h00);
    rx_valid = 1'b0;
    tx_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    applyStimulus();
  endtask

  initial begin
    logic [95:0]   r;
    logic [FW-1:0] tx_ref;
    int            p;

    rst = 1'b1; rx_byte = '0; rx_valid = 1'b0; frame_ready = 1'b0;
    tx_frame = '0; tx_start = 1'b0; tx_ready = 1'b0;
    exp_hold = 1'b0; exp_idle = 0; exp_frame_m = '0; exp_frame_l = '0;

    applyStimulus();
    applyStimulus();
    checkZero("reset");
    rst = 1'b0;

    // Bytes 0x01..0x0A with short random gaps, held while frame_ready is low
    for (int i = 1; i <= NB; i++) begin
      sendByte(8'(i));
      repeat ($urandom_range(0, 3)) applyStimulus();
    end
    repeat (3) applyStimulus();
    checkOutput("m.hold_frame", frame_data_m, 80'h0102030405060708090A);
    checkOutput("l.hold_frame", frame_data_l, 80'h0A090807060504030201);
    checkOutput("m.hold_valid", FW'(frame_valid_m), FW'(1'b1));

    sendByte(8'hFF);
    checkOutput("m.overrun_pulse", FW'(rx_overrun_m), FW'(1'b1));
    checkOutput("m.overrun_frame", frame_data_m, 80'h0102030405060708090A);
    applyStimulus();
    checkOutput("m.overrun_clear", FW'(rx_overrun_m), FW'(1'b0));

    frame_ready = 1'b1;
    sendByte(8'hEE);
    frame_ready = 1'b0;
    checkOutput("m.release_valid", FW'(frame_valid_m), FW'(1'b0));
    checkOutput("m.release_overrun", FW'(rx_overrun_m), FW'(1'b1));

    // Partial frame, then 16 idle cycles: timeout
    for (int i = 0; i < 3; i++) sendByte(8'h31 + 8'(i));
    repeat (TMO) applyStimulus();
    checkOutput("m.timeout_pulse", FW'(timeout_err_m), FW'(1'b1));
    for (int i = 0; i < NB; i++) sendByte(8'hA0 + 8'(i));
    checkOutput("m.after_timeout", frame_data_m, 80'hA0A1A2A3A4A5A6A7A8A9);
    checkOutput("m.after_timeout_tmo", FW'(timeout_err_m), FW'(1'b0));
    frame_ready = 1'b1;
    applyStimulus();
    frame_ready = 1'b0;

    // Byte arriving on the cycle the timeout would fire is accepted
    sendByte(8'hB0);
    sendByte(8'hB1);
    repeat (TMO - 1) applyStimulus();
    sendByte(8'hB2);
    checkOutput("m.priority_tmo", FW'(timeout_err_m), FW'(1'b0));
    for (int i = 3; i < NB; i++) sendByte(8'hB0 + 8'(i));
    checkOutput("m.priority_frame", frame_data_m, 80'hB0B1B2B3B4B5B6B7B8B9);
    frame_ready = 1'b1;
    applyStimulus();
    frame_ready = 1'b0;

    // Transmit with tx_ready toggling and an ignored second request
    tx_ref = 80'h11223344556677889900;
    sent_m.delete();
    sent_l.delete();
    tx_frame = tx_ref;
    tx_start = 1'b1;
    applyStimulus();
    tx_frame = 80'hDEADBEEFDEADBEEFDEAD;
    for (int k = 0; k < 40; k++) begin
      tx_ready = (k % 2 == 0);
      if (k == 5) tx_start = 1'b1;
      applyStimulus();
    end
    tx_ready = 1'b0;
    checkOutput("m.tx_count", FW'(sent_m.size()), FW'(NB));
    checkOutput("l.tx_count", FW'(sent_l.size()), FW'(NB));
    for (int i = 0; i < NB && i < sent_m.size() && i < sent_l.size(); i++) begin
      checkOutput("m.tx_order", FW'(sent_m[i]), FW'(8'(tx_ref >> (8 * (NB - 1 - i)))));
      checkOutput("l.tx_order", FW'(sent_l[i]), FW'(8'(tx_ref >> (8 * i))));
    end
    checkOutput("m.tx_busy_end", FW'(tx_busy_m), FW'(1'b0));

    // Reset in the middle of both a receive and a transmit
    r = {$urandom(), $urandom(), $urandom()};
    tx_frame = r[FW-1:0];
    tx_start = 1'b1;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      tx_ready = (i < 4);
      sendByte(8'h50 + 8'(i));
    end
    rst = 1'b1;
    tx_ready = 1'b0;
    applyStimulus();
    checkZero("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < NB; i++) sendByte(8'h60 + 8'(i));
    checkOutput("m.post_reset", frame_data_m, 80'h60616263646566676869);
    checkOutput("l.post_reset", frame_data_l, 80'h69686766656463626160);
    frame_ready = 1'b1;
    applyStimulus();

    // Random traffic; every third segment is sparse so timeouts occur
    for (int seg = 0; seg < 12; seg++) begin
      p = (seg % 3 == 2) ? 3 : 50;
      for (int k = 0; k < 200; k++) begin
        rx_valid    = ($urandom_range(0, 99) < p);
        rx_byte     = 8'($urandom());
        frame_ready = ($urandom_range(0, 99) < 30);
        tx_ready    = ($urandom_range(0, 1) == 1);
        tx_start    = ($urandom_range(0, 9) == 0);
        r           = {$urandom(), $urandom(), $urandom()};
        tx_frame    = r[FW-1:0];
        rst         = ($urandom_range(0, 499) == 0);
        applyStimulus();
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_link.md
FRAME_LINK -- requirements
Module: frame_link

Interface
REQ-001 Parameter BYTE_W, default 8, bit width of one link byte.
REQ-002 Parameter NBYTES, default 10, bytes per frame (frame width FW = NBYTES*BYTE_W, 80 by default); legal range 2..64.
REQ-003 Parameter MSB_FIRST, default 1; 1 = byte slot 0 maps to frame bits [FW-1:FW-BYTE_W], 0 = slot 0 maps to bits [BYTE_W-1:0].
REQ-004 Parameter TIMEOUT, default 1000000, inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx_byte  input  BYTE_W  received byte from the UART receiver.
REQ-008 rx_valid  input  1  one-cycle strobe, rx_byte valid.
REQ-009 frame_data  output  FW  assembled frame.
REQ-010 frame_valid  output  1  frame_data holds a complete frame.
REQ-011 frame_ready  input  1  consumer accepts the frame.
REQ-012 rx_overrun  output  1  one-cycle pulse, byte dropped.
REQ-013 timeout_err  output  1  one-cycle pulse, partial frame discarded.
REQ-014 tx_frame  input  FW  frame to transmit.
REQ-015 tx_start  input  1  one-cycle request to transmit tx_frame.
REQ-016 tx_busy  output  1  transmit in progress.
REQ-017 tx_byte  output  BYTE_W  byte to the UART transmitter.
REQ-018 tx_valid  output  1  tx_byte valid.
REQ-019 tx_ready  input  1  UART transmitter accepts tx_byte.

Function
REQ-020 Receive FSM SHALL have states R_IDLE, R_FILL, R_HOLD; slot counter 0..NBYTES-1.
REQ-021 In R_IDLE or R_FILL, rx_valid SHALL write rx_byte into the current slot and increment the counter; R_IDLE moves to R_FILL on the first byte.
REQ-022 The byte written into slot NBYTES-1 SHALL move the FSM to R_HOLD, with frame_valid high on the next cycle and the counter cleared.
REQ-023 In R_HOLD, frame_data SHALL be stable and frame_valid high until a cycle with frame_ready high, after which the FSM returns to R_IDLE and frame_valid drops next cycle.
REQ-024 rx_valid in R_HOLD, including the cycle frame_ready is high, SHALL drop the byte and pulse rx_overrun for one cycle.
REQ-025 In R_FILL, an idle counter SHALL count cycles since the last accepted byte; at TIMEOUT it SHALL discard the partial frame, clear the counter, return to R_IDLE, and pulse timeout_err for one cycle (TIMEOUT != 0 only).
REQ-026 rx_valid in the same cycle the timeout fires SHALL take priority: the byte is accepted and the idle counter restarts.
REQ-027 Transmit FSM SHALL have states T_IDLE, T_SEND; tx_start in T_IDLE SHALL latch tx_frame, set slot index 0, and raise tx_busy and tx_valid the next cycle.
REQ-028 In T_SEND, tx_byte SHALL present the latched slot at the current index using the MSB_FIRST mapping; it SHALL hold while tx_valid is high and tx_ready is low.
REQ-029 tx_valid and tx_ready both high SHALL advance the index; acceptance of slot NBYTES-1 SHALL return to T_IDLE and drop tx_valid and tx_busy the next cycle.
REQ-030 tx_start while tx_busy is high SHALL be ignored; tx_frame changes after latching SHALL have no effect.
REQ-031 Receive and transmit paths SHALL be fully independent and operate concurrently.

Reset
REQ-032 rst SHALL, in any state including mid-frame, force R_IDLE and T_IDLE and clear all counters.
REQ-033 On the cycle after rst, all outputs SHALL be zero.

Verification
REQ-034 Defaults; feed bytes 0x01..0x0A with gaps -> frame_valid=1 with frame_data=0x0102030405060708090A; hold while frame_ready=0, drop one cycle after frame_ready=1.
REQ-035 MSB_FIRST=0; same bytes -> frame_data=0x0A090807060504030201.
REQ-036 Complete frame held; rx_valid with 0xFF -> rx_overrun one-cycle pulse, frame_data unchanged.
REQ-037 TIMEOUT=16; send 3 bytes, then idle 16 cycles -> timeout_err pulse; next 10 bytes 0xA0..0xA9 -> frame_data=0xA0A1A2A3A4A5A6A7A8A9.
REQ-038 tx_start with 0x11223344556677889900, tx_ready toggling 1/0, second tx_start mid-send -> 10 bytes output 0x11,0x22,...,0x00 in order, second request ignored, tx_busy falls after the last byte.
REQ-039 rst asserted after 5 of 10 bytes received and 4 of 10 sent -> all outputs 0 next cycle; the next complete 10-byte sequence assembles correctly.
